// File: rtl/tdm_8to1_mux.sv
// Sequential 8-to-1 TDM: captures eight channels on start and then drives them slot by slot with a 3-bit select.
// Optional frame parity output p is built only when TDM_MUX_PARITY_EN is defined.
module tdm_8to1_mux #(
  parameter int W    = 1,
  parameter int HOLD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  input  logic [W-1:0] i4,
  input  logic [W-1:0] i5,
  input  logic [W-1:0] i6,
  input  logic [W-1:0] i7,
  input  logic [W-1:0] i8,
  input  logic         start,
  output logic [W-1:0] y,
  output logic         s1,
  output logic         s2,
  output logic         s3,
  output logic         valid,
  output logic         busy,
`ifdef TDM_MUX_PARITY_EN
  output logic         done,
  output logic         p
`else
  output logic         done
`endif
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic {IDLE, SCAN} stateT;

  stateT         r_state;
  logic [2:0]    r_slot;
  logic [HW-1:0] r_hold;
  logic [W-1:0]  r_shadow [8];

  logic [W-1:0]  w_inVec [8];
  logic          w_lastCycle;
  logic          w_capture;
  logic [2:0]    w_nextSlot;
  logic [HW-1:0] w_nextHold;
  logic          w_nextDone;
`ifdef TDM_MUX_PARITY_EN
  logic          w_parity;
  assign w_parity = ^{i1, i2, i3, i4, i5, i6, i7, i8};
`endif

  assign w_inVec[0] = i1;
  assign w_inVec[1] = i2;
  assign w_inVec[2] = i3;
  assign w_inVec[3] = i4;
  assign w_inVec[4] = i5;
  assign w_inVec[5] = i6;
  assign w_inVec[6] = i7;
  assign w_inVec[7] = i8;

  // The final cycle of slot 7 is the only point where a busy block accepts a new start.
  assign w_lastCycle = (r_state == SCAN) && (r_slot == 3'd7) && (r_hold == HOLD_LAST);
  assign w_capture   = start && ((r_state == IDLE) || w_lastCycle);

  always_comb begin
    w_nextSlot = r_slot;
    w_nextHold = r_hold + HOLD_ONE;
    if (r_hold == HOLD_LAST) begin
      w_nextSlot = r_slot + 3'd1;
      w_nextHold = '0;
    end
    w_nextDone = (w_nextSlot == 3'd7) && (w_nextHold == HOLD_LAST);
  end

  // Outputs are loaded with the value of the coming cycle, so y/s already show slot 0 right after capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_hold  <= '0;
      for (int k = 0; k < 8; k++) r_shadow[k] <= '0;
      y            <= '0;
      {s1, s2, s3} <= 3'b000;
      valid        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef TDM_MUX_PARITY_EN
      p            <= 1'b0;
`endif
    end else if (w_capture) begin
      r_state      <= SCAN;
      r_slot       <= '0;
      r_hold       <= '0;
      r_shadow     <= w_inVec;
      y            <= i1;
      {s1, s2, s3} <= 3'b000;
      valid        <= 1'b1;
      busy         <= 1'b1;
      done         <= 1'b0;
`ifdef TDM_MUX_PARITY_EN
      p            <= w_parity;
`endif
    end else if (r_state == SCAN) begin
      if (w_lastCycle) begin
        r_state <= IDLE;
        valid   <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b0;
`ifdef TDM_MUX_PARITY_EN
        p       <= 1'b0;
`endif
      end else begin
        r_slot       <= w_nextSlot;
        r_hold       <= w_nextHold;
        y            <= r_shadow[w_nextSlot];
        {s1, s2, s3} <= w_nextSlot;
        done         <= w_nextDone;
      end
    end
  end

endmodule

// File: tb/tb_tdm_8to1_mux.sv
// Bench for tdm_8to1_mux: unit 0 is W=1/HOLD=1, unit 1 is W=4/HOLD=3, both checked against a frame-position model.
module tb_tdm_8to1_mux;

  logic       clk = 1'b0;
  logic       rstIn   [2];
  logic       startIn [2];
  logic [3:0] chIn    [2][8];

  logic       yA, validA, busyA, doneA, pA;
  logic [2:0] sA;
  logic [3:0] yB;
  logic       validB, busyB, doneB, pB;
  logic [2:0] sB;

  int passCount  = 0;
  int checkCount = 0;

  // Model state: frame position counts cycles since capture, slot = position / HOLD.
  int holdOf [2] = '{1, 3};
  int maskOf [2] = '{1, 15};
  bit mActive [2];
  int mPos    [2];
  int mData   [2][8];
  int mY [2], mS [2], mPar [2];

  typedef struct {
    logic       start;
    logic [7:0] data;
    logic       v;
    logic       b;
    logic       d;
    logic [2:0] s;
    logic       y;
  } vecT;

  always #5 clk = ~clk;

  tdm_8to1_mux #(.W(1), .HOLD(1)) dutA (
    .clk(clk), .rst(rstIn[0]),
    .i1(chIn[0][0][0:0]), .i2(chIn[0][1][0:0]), .i3(chIn[0][2][0:0]), .i4(chIn[0][3][0:0]),
    .i5(chIn[0][4][0:0]), .i6(chIn[0][5][0:0]), .i7(chIn[0][6][0:0]), .i8(chIn[0][7][0:0]),
    .start(startIn[0]), .y(yA), .s1(sA[2]), .s2(sA[1]), .s3(sA[0]),
    .valid(validA), .busy(busyA),
`ifdef TDM_MUX_PARITY_EN
    .done(doneA), .p(pA)
`else
    .done(doneA)
`endif
  );

  tdm_8to1_mux #(.W(4), .HOLD(3)) dutB (
    .clk(clk), .rst(rstIn[1]),
    .i1(chIn[1][0]), .i2(chIn[1][1]), .i3(chIn[1][2]), .i4(chIn[1][3]),
    .i5(chIn[1][4]), .i6(chIn[1][5]), .i7(chIn[1][6]), .i8(chIn[1][7]),
    .start(startIn[1]), .y(yB), .s1(sB[2]), .s2(sB[1]), .s3(sB[0]),
    .valid(validB), .busy(busyB),
`ifdef TDM_MUX_PARITY_EN
    .done(doneB), .p(pB)
`else
    .done(doneB)
`endif
  );

`ifndef TDM_MUX_PARITY_EN
  assign pA = 1'b0;
  assign pB = 1'b0;
`endif

  function automatic void checkVal(string name, logic [15:0] act, logic [15:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void modelStep(int u);
    int last = 8 * holdOf[u] - 1;
    logic par;
    if (rstIn[u]) begin
      mActive[u] = 1'b0; mPos[u] = 0; mY[u] = 0; mS[u] = 0; mPar[u] = 0;
    end else if (startIn[u] && (!mActive[u] || mPos[u] == last)) begin
      par = 1'b0;
      for (int k = 0; k < 8; k++) begin
        mData[u][k] = int'(chIn[u][k]) & maskOf[u];
        par = par ^ (^mData[u][k]);
      end
      mActive[u] = 1'b1; mPos[u] = 0; mPar[u] = int'(par);
    end else if (mActive[u] && mPos[u] == last) begin
      mActive[u] = 1'b0; mPar[u] = 0;
    end else if (mActive[u]) begin
      mPos[u]++;
    end
    if (mActive[u]) begin
      mS[u] = mPos[u] / holdOf[u];
      mY[u] = mData[u][mS[u]];
    end
  endfunction

  task automatic checkOutput(int u);
    logic [15:0] act, exp;
    logic d;
    d = mActive[u] && (mPos[u] == 8 * holdOf[u] - 1);
    exp = {6'b0, mActive[u], mActive[u], d, 3'(mS[u]), 4'(mY[u])};
    if (u == 0) act = {6'b0, validA, busyA, doneA, sA, 3'b0, yA};
    else        act = {6'b0, validB, busyB, doneB, sB, yB};
    checkVal(u == 0 ? "unitA outputs" : "unitB outputs", act, exp);
`ifdef TDM_MUX_PARITY_EN
    checkVal(u == 0 ? "unitA parity" : "unitB parity", {15'b0, (u == 0) ? pA : pB}, 16'(mPar[u]));
`endif
  endtask

  task automatic applyStimulus();
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
    checkOutput(0);
    checkOutput(1);
  endtask

  task automatic setData(int u, logic [7:0] bits);
    for (int k = 0; k < 8; k++) chIn[u][k] = {3'b000, bits[k]};
  endtask

  initial begin
    vecT tbl [9];
    int  doneTick;
    int  validDrops;
    logic [7:0] d2;

    // bit k of data = channel i(k+1); 8'h4D encodes i1..i8 = 1,0,1,1,0,0,1,0
    tbl[0] = '{1'b1, 8'h4D, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[1] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1};
    tbl[3] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0};
    tbl[5] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0};
    tbl[6] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd6, 1'b1};
    tbl[7] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0};
    tbl[8] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0};

    for (int u = 0; u < 2; u++) begin
      rstIn[u] = 1'b1; startIn[u] = 1'b1;
      for (int k = 0; k < 8; k++) chIn[u][k] = 4'hF;
    end
    #1;
    applyStimulus();
    applyStimulus();
    checkVal("reset state A", {validA, busyA, doneA, sA, yA, pA}, 8'h00);
    checkVal("reset state B", {validB, busyB, doneB, sB, yB, pB}, 11'h000);

    rstIn[0] = 1'b0; rstIn[1] = 1'b0; startIn[0] = 1'b0; startIn[1] = 1'b0;
    for (int t = 0; t < 20; t++) begin
      applyStimulus();
      checkVal("idle valid/busy A", {14'b0, validA, busyA}, 16'h0);
    end

    // Single frame plus ignored mid-frame starts on unit A
    for (int i = 0; i < 9; i++) begin
      startIn[0] = tbl[i].start;
      setData(0, tbl[i].data);
      applyStimulus();
      checkVal($sformatf("table row %0d", i), {validA, busyA, doneA, sA, yA},
               {tbl[i].v, tbl[i].b, tbl[i].d, tbl[i].s, tbl[i].y});
    end
    startIn[0] = 1'b0;

    // HOLD=3 frame on unit B: i(k) = k
    for (int k = 0; k < 8; k++) chIn[1][k] = 4'(k + 1);
    doneTick = 0;
    for (int t = 1; t <= 30; t++) begin
      startIn[1] = (t == 1);
      applyStimulus();
      if (t <= 24) checkVal("hold3 y value", {12'b0, yB}, 16'((t - 1) / 3 + 1));
      if (doneB && doneTick == 0) doneTick = t;
    end
    checkVal("hold3 done tick", 16'(doneTick), 16'd24);

    // Back-to-back frames on unit A with start held high; inputs change mid-frame
    d2 = 8'h3C;
    setData(0, 8'hA5);
    startIn[0] = 1'b1;
    validDrops = 0;
    for (int t = 1; t <= 16; t++) begin
      if (t == 5) setData(0, d2);
      applyStimulus();
      if (!validA) validDrops++;
      if (t >= 9) checkVal("second frame data", {15'b0, yA}, {15'b0, d2[t - 9]});
    end
    checkVal("back-to-back valid gaps", 16'(validDrops), 16'd0);
    startIn[0] = 1'b0;
    for (int t = 0; t < 10; t++) applyStimulus();

    // Reset during slot 4 on unit A
    setData(0, 8'hFF);
    startIn[0] = 1'b1;
    applyStimulus();
    startIn[0] = 1'b0;
    for (int t = 0; t < 4; t++) applyStimulus();
    checkVal("slot before reset", {13'b0, sA}, 16'd4);
    rstIn[0] = 1'b1;
    startIn[0] = 1'b1;
    applyStimulus();
    checkVal("mid-frame reset", {validA, busyA, doneA, sA, yA, pA}, 8'h00);
    rstIn[0] = 1'b0;
    applyStimulus();
    checkVal("restart after reset", {validA, sA}, 4'b1000);
    startIn[0] = 1'b0;
    for (int t = 0; t < 10; t++) applyStimulus();

    // Randomized traffic on both units
    for (int t = 0; t < 400; t++) begin
      for (int u = 0; u < 2; u++) begin
        rstIn[u]   = ($urandom_range(0, 39) == 0);
        startIn[u] = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < 8; k++) chIn[u][k] = 4'($urandom);
      end
      applyStimulus();
    end
    for (int u = 0; u < 2; u++) begin
      rstIn[u] = 1'b0; startIn[u] = 1'b0;
    end
    for (int t = 0; t < 30; t++) applyStimulus();

`ifdef TDM_MUX_PARITY_EN
    // Parity constants: 1,1,1,0,0,0,0,0 -> 1 ; all ones -> 0
    setData(0, 8'h07);
    startIn[0] = 1'b1;
    for (int t = 0; t < 8; t++) begin
      applyStimulus();
      startIn[0] = 1'b0;
      checkVal("parity odd frame", {15'b0, pA}, 16'd1);
    end
    applyStimulus();
    checkVal("parity idle", {15'b0, pA}, 16'd0);
    setData(0, 8'hFF);
    startIn[0] = 1'b1;
    for (int t = 0; t < 8; t++) begin
      applyStimulus();
      startIn[0] = 1'b0;
      checkVal("parity even frame", {15'b0, pA}, 16'd0);
    end
    applyStimulus();
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
